// File: rtl/wdt_pkg.sv
// Shared types and helpers for the multi-channel transaction watchdog.
// Includes the per-channel state encoding and the limit normalisation.
package wdt_pkg;

   typedef enum logic [1:0] {
      WDT_IDLE    = 2'd0,
      WDT_ACTIVE  = 2'd1,
      WDT_TIMEOUT = 2'd2
   } wdt_state_t;

   // A zero limit would never expire, so it is treated as a one-cycle limit.
   function automatic logic [31:0] wdt_norm_limit(input logic [31:0] limit);
      return (limit == 32'd0) ? 32'd1 : limit;
   endfunction

endpackage

// File: rtl/watchdog_channel.sv
// One watchdog channel: IDLE/ACTIVE/TIMEOUT FSM, cycle counter and latched limit.
// timeout_pulse is the combinational "entering TIMEOUT on this edge" strobe for the event counter.
module watchdog_channel
   import wdt_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             complete,
   input  logic             clear,
   input  logic [CNT_W-1:0] timeout_limit,
   output logic             busy,
   output logic             req_timeout,
   output logic             timeout_pulse
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   wdt_state_t       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] limit_q, limit_d;
   logic [CNT_W-1:0] norm_limit;

   assign norm_limit = CNT_W'(wdt_norm_limit(32'(timeout_limit)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WDT_IDLE;
         count_q <= '0;
         limit_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         limit_q <= limit_d;
      end
   end

   // Completion beats retrigger, which beats expiry; TIMEOUT only listens to clear.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      limit_d = limit_q;
      case (state_q)
         WDT_IDLE: begin
            if (start) begin
               state_d = WDT_ACTIVE;
               count_d = '0;
               limit_d = norm_limit;
            end
         end
         WDT_ACTIVE: begin
            if (complete && start) begin
               count_d = '0;
               limit_d = norm_limit;
            end else if (complete) begin
               state_d = WDT_IDLE;
            end else if (start) begin
               count_d = '0;
               limit_d = norm_limit;
            end else if (count_q == limit_q - ONE) begin
               state_d = WDT_TIMEOUT;
            end else begin
               count_d = count_q + ONE;
            end
         end
         WDT_TIMEOUT: begin
            if (clear) begin
               state_d = WDT_IDLE;
            end
         end
         default: begin
            state_d = WDT_IDLE;
         end
      endcase
   end

   assign busy          = (state_q == WDT_ACTIVE);
   assign req_timeout   = (state_q == WDT_TIMEOUT);
   assign timeout_pulse = (state_q == WDT_ACTIVE) && (state_d == WDT_TIMEOUT);

endmodule

// File: rtl/multi_channel_watchdog.sv
// NUM_CH independent transaction watchdogs with a shared sticky-timeout summary
// and a saturating count of timeout events since reset.
module multi_channel_watchdog
   import wdt_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 8,
   parameter int EVT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] start_transaction,
   input  logic [NUM_CH-1:0] complete_transaction,
   input  logic [NUM_CH-1:0] clear_timeout,
   input  logic [CNT_W-1:0]  timeout_limit,
   output logic [NUM_CH-1:0] busy,
   output logic [NUM_CH-1:0] req_timeout,
   output logic              timeout_any,
   output logic [EVT_W-1:0]  timeout_events
);

   localparam int PC_W  = $clog2(NUM_CH + 1);
   localparam int SUM_W = ((EVT_W > PC_W) ? EVT_W : PC_W) + 1;
   localparam logic [SUM_W-1:0] EVT_MAX = SUM_W'({EVT_W{1'b1}});

   logic [NUM_CH-1:0] timeout_pulse;
   logic [PC_W-1:0]   pulse_count;
   logic [SUM_W-1:0]  event_sum;
   logic [EVT_W-1:0]  events_d;

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      watchdog_channel #(
         .CNT_W(CNT_W)
      ) u_channel (
         .clk           (clk),
         .rst_n         (rst_n),
         .start         (start_transaction[ch]),
         .complete      (complete_transaction[ch]),
         .clear         (clear_timeout[ch]),
         .timeout_limit (timeout_limit),
         .busy          (busy[ch]),
         .req_timeout   (req_timeout[ch]),
         .timeout_pulse (timeout_pulse[ch])
      );
   end

   assign timeout_any = |req_timeout;

   // Several channels may expire on the same edge, so add their popcount and clamp.
   always_comb begin
      pulse_count = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         pulse_count = pulse_count + PC_W'(timeout_pulse[i]);
      end
      event_sum = SUM_W'(timeout_events) + SUM_W'(pulse_count);
      events_d  = (event_sum > EVT_MAX) ? {EVT_W{1'b1}} : event_sum[EVT_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timeout_events <= '0;
      end else begin
         timeout_events <= events_d;
      end
   end

endmodule

// File: tb/tb_multi_channel_watchdog.sv
// Directed bench for multi_channel_watchdog; a second instance with a 2-bit
// event counter shares the stimulus so saturation is observed alongside.
module tb_multi_channel_watchdog;

   typedef struct {
      string       tag;
      int          kind;
      logic [31:0] value;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] start_transaction = '0;
   logic [3:0] complete_transaction = '0;
   logic [3:0] clear_timeout = '0;
   logic [7:0] timeout_limit = '0;

   logic [3:0]  busy, req_timeout;
   logic        timeout_any;
   logic [15:0] timeout_events;
   logic [3:0]  busy_s, req_timeout_s;
   logic        timeout_any_s;
   logic [1:0]  timeout_events_s;

   exp_t sb[$];
   int   vector_count = 0;
   int   miss_count = 0;
   int   exp_events = 0;

   always #5 clk = ~clk;

   multi_channel_watchdog #(.NUM_CH(4), .CNT_W(8), .EVT_W(16)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .start_transaction    (start_transaction),
      .complete_transaction (complete_transaction),
      .clear_timeout        (clear_timeout),
      .timeout_limit        (timeout_limit),
      .busy                 (busy),
      .req_timeout          (req_timeout),
      .timeout_any          (timeout_any),
      .timeout_events       (timeout_events)
   );

   multi_channel_watchdog #(.NUM_CH(4), .CNT_W(8), .EVT_W(2)) sat_dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .start_transaction    (start_transaction),
      .complete_transaction (complete_transaction),
      .clear_timeout        (clear_timeout),
      .timeout_limit        (timeout_limit),
      .busy                 (busy_s),
      .req_timeout          (req_timeout_s),
      .timeout_any          (timeout_any_s),
      .timeout_events       (timeout_events_s)
   );

   // Drive one edge's worth of inputs, let the edge happen, then drop the pulses.
   task automatic applyStimulus(input logic [3:0] s, input logic [3:0] c,
                                input logic [3:0] cl, input logic [7:0] lim);
      start_transaction    = s;
      complete_transaction = c;
      clear_timeout        = cl;
      timeout_limit        = lim;
      @(posedge clk);
      #1;
      start_transaction    = '0;
      complete_transaction = '0;
      clear_timeout        = '0;
   endtask

   task automatic idleCycles(input int n, input logic [7:0] lim);
      for (int i = 0; i < n; i++) applyStimulus(4'b0, 4'b0, 4'b0, lim);
   endtask

   task automatic expectAll(input string tag, input logic [3:0] b,
                            input logic [3:0] rt, input int ev);
      int sat;
      sat = (ev > 3) ? 3 : ev;
      sb.push_back('{tag: {tag, ".busy"},   kind: 0, value: 32'(b)});
      sb.push_back('{tag: {tag, ".rt"},     kind: 1, value: 32'(rt)});
      sb.push_back('{tag: {tag, ".any"},    kind: 2, value: 32'(|rt)});
      sb.push_back('{tag: {tag, ".events"}, kind: 3, value: 32'(ev)});
      sb.push_back('{tag: {tag, ".sat"},    kind: 4, value: 32'(sat)});
      sb.push_back('{tag: {tag, ".satch"},  kind: 5, value: 32'({|rt, rt, b})});
   endtask

   task automatic checkOutput();
      exp_t        e;
      logic [31:0] obs;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.kind)
            0:       obs = 32'(busy);
            1:       obs = 32'(req_timeout);
            2:       obs = 32'(timeout_any);
            3:       obs = 32'(timeout_events);
            4:       obs = 32'(timeout_events_s);
            default: obs = 32'({timeout_any_s, req_timeout_s, busy_s});
         endcase
         vector_count++;
         assert (obs === e.value) else begin
            miss_count++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.value);
         end
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout observed=running expected=finished");
      $fatal(1, "[TB] simulation time limit expired");
   end

   initial begin
      // Power-on reset
      repeat (3) @(posedge clk);
      #1;
      expectAll("reset_hold", 4'b0, 4'b0, 0);
      checkOutput();
      rst_n = 1'b1;
      expectAll("reset_release", 4'b0, 4'b0, 0);
      checkOutput();

      // Reset while channel 0 is ACTIVE clears it; no timeout at the old deadline
      applyStimulus(4'b0001, 4'b0, 4'b0, 8'd5);
      expectAll("rst_mid.active", 4'b0001, 4'b0, 0);
      checkOutput();
      idleCycles(2, 8'd5);
      rst_n = 1'b0;
      #1;
      expectAll("rst_mid.async", 4'b0, 4'b0, 0);
      checkOutput();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idleCycles(5, 8'd5);
      expectAll("rst_mid.old_deadline", 4'b0, 4'b0, 0);
      checkOutput();

      // Normal completion at E+3 with L=5
      applyStimulus(4'b0001, 4'b0, 4'b0, 8'd5);
      expectAll("normal.e", 4'b0001, 4'b0, 0);
      checkOutput();
      idleCycles(2, 8'd5);
      expectAll("normal.e2", 4'b0001, 4'b0, 0);
      checkOutput();
      applyStimulus(4'b0, 4'b0001, 4'b0, 8'd5);
      expectAll("normal.e3", 4'b0, 4'b0, 0);
      checkOutput();
      idleCycles(5, 8'd5);
      expectAll("normal.after", 4'b0, 4'b0, 0);
      checkOutput();

      // Completion exactly at E+L wins over the timeout
      applyStimulus(4'b0001, 4'b0, 4'b0, 8'd5);
      idleCycles(4, 8'd5);
      expectAll("bound.e4", 4'b0001, 4'b0, 0);
      checkOutput();
      applyStimulus(4'b0, 4'b0001, 4'b0, 8'd5);
      expectAll("bound.complete_e5", 4'b0, 4'b0, 0);
      checkOutput();

      // Without completion the timeout fires after E+L
      applyStimulus(4'b0001, 4'b0, 4'b0, 8'd5);
      idleCycles(4, 8'd5);
      expectAll("bound.nocomp_e4", 4'b0001, 4'b0, 0);
      checkOutput();
      applyStimulus(4'b0, 4'b0, 4'b0, 8'd5);
      exp_events = 1;
      expectAll("bound.timeout_e5", 4'b0, 4'b0001, exp_events);
      checkOutput();

      // Sticky timeout on ch1 ignores start and complete until cleared
      applyStimulus(4'b0010, 4'b0, 4'b0, 8'd2);
      idleCycles(2, 8'd2);
      exp_events = 2;
      expectAll("sticky.timeout", 4'b0, 4'b0011, exp_events);
      checkOutput();
      for (int i = 0; i < 10; i++) applyStimulus(4'b0010, (i % 2 == 0) ? 4'b0010 : 4'b0, 4'b0, 8'd2);
      expectAll("sticky.ignore", 4'b0, 4'b0011, exp_events);
      checkOutput();
      applyStimulus(4'b0010, 4'b0010, 4'b0010, 8'd2);
      expectAll("sticky.clear_start", 4'b0, 4'b0001, exp_events);
      checkOutput();
      applyStimulus(4'b0010, 4'b0, 4'b0, 8'd2);
      expectAll("sticky.restart", 4'b0010, 4'b0001, exp_events);
      checkOutput();
      applyStimulus(4'b0, 4'b0010, 4'b0001, 8'd2);
      expectAll("sticky.tidy", 4'b0, 4'b0, exp_events);
      checkOutput();

      // All four channels expire on the same edge
      applyStimulus(4'b1111, 4'b0, 4'b0, 8'd3);
      idleCycles(2, 8'd3);
      expectAll("multi.e2", 4'b1111, 4'b0, exp_events);
      checkOutput();
      applyStimulus(4'b0, 4'b0, 4'b0, 8'd3);
      exp_events = 6;
      expectAll("multi.e3", 4'b0, 4'b1111, exp_events);
      checkOutput();
      applyStimulus(4'b0, 4'b0, 4'b0100, 8'd3);
      expectAll("multi.clear2", 4'b0, 4'b1011, exp_events);
      checkOutput();
      applyStimulus(4'b0, 4'b0, 4'b1011, 8'd3);
      expectAll("multi.clear_all", 4'b0, 4'b0, exp_events);
      checkOutput();

      // Retrigger relatches the new limit; later limit changes do not affect it
      applyStimulus(4'b0001, 4'b0, 4'b0, 8'd4);
      applyStimulus(4'b0, 4'b0, 4'b0, 8'd20);
      applyStimulus(4'b0001, 4'b0, 4'b0, 8'd20);
      idleCycles(2, 8'd3);
      expectAll("retrig.e4", 4'b0001, 4'b0, exp_events);
      checkOutput();
      idleCycles(17, 8'd3);
      expectAll("retrig.e21", 4'b0001, 4'b0, exp_events);
      checkOutput();
      applyStimulus(4'b0, 4'b0, 4'b0, 8'd3);
      exp_events = 7;
      expectAll("retrig.e22", 4'b0, 4'b0001, exp_events);
      checkOutput();
      applyStimulus(4'b0, 4'b0, 4'b0001, 8'd3);

      // A zero limit behaves as a one-cycle limit
      applyStimulus(4'b1000, 4'b0, 4'b0, 8'd0);
      expectAll("zero.e", 4'b1000, 4'b0, exp_events);
      checkOutput();
      applyStimulus(4'b0, 4'b0, 4'b0, 8'd0);
      exp_events = 8;
      expectAll("zero.e1", 4'b0, 4'b1000, exp_events);
      checkOutput();
      applyStimulus(4'b0, 4'b0, 4'b1000, 8'd0);
      expectAll("zero.clear", 4'b0, 4'b0, exp_events);
      checkOutput();

      $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
      $finish;
   end

endmodule

// File: doc/multi_channel_watchdog.md
# multi_channel_watchdog

Parametrised, multi-channel successor to the single-channel transaction watchdog. It tracks up to NUM_CH independent outstanding transactions, each with its own start/complete pair and its own cycle counter. A channel that does not see completion within a programmable limit raises a sticky per-channel timeout, which software clears explicitly. The block sits beside the request issuers and feeds interrupt/error logic through `timeout_any` and a saturating event counter.

## Interface
- NUM_CH, 4, number of independent channels (1..32)
- CNT_W, 8, counter and limit width
- EVT_W, 16, width of the saturating timeout event counter
- clk  in  1  single clock; all logic is rising-edge
- rst_n  in  1  reset, asynchronous assert, active-low; one clock, reset asynchronous and active-low
- start_transaction  in  NUM_CH  per-channel start pulse
- complete_transaction  in  NUM_CH  per-channel completion pulse
- clear_timeout  in  NUM_CH  per-channel sticky-timeout clear
- timeout_limit  in  CNT_W  shared limit L in cycles; sampled per channel at start
- busy  out  NUM_CH  channel in ACTIVE
- req_timeout  out  NUM_CH  channel in TIMEOUT (sticky)
- timeout_any  out  1  OR of req_timeout
- timeout_events  out  EVT_W  total timeout events since reset, saturating

## Operation
- Each channel has a state machine with states IDLE, ACTIVE and TIMEOUT, a CNT_W counter, and a latched limit.
- IDLE:
  - start=1 → ACTIVE; count←0; latched limit←timeout_limit.
  - A latched limit of 0 is stored as 1.
  - complete and clear in IDLE are ignored.
- ACTIVE, evaluated per edge in priority order:
  - complete=1 and start=1 → stay ACTIVE (back-to-back); count←0; relatch the limit.
  - complete=1 → IDLE.
  - start=1 without complete → retrigger: count←0; relatch the limit.
  - count == latched−1 → TIMEOUT.
  - Otherwise count←count+1.
- TIMEOUT:
  - Held until clear=1 → IDLE.
  - start and complete are ignored, including when they arrive in the same cycle as clear.
- A change to timeout_limit never affects a channel already ACTIVE.
- Event counter:
  - On each edge, add the number of channels entering TIMEOUT on that edge (popcount).
  - Saturate at 2^EVT_W−1; no wrap.
- Reset returns all channels to IDLE, count 0 and latched limit 0, mid-transaction or not.
- Reset outputs: busy=0, req_timeout=0, timeout_any=0, timeout_events=0.

## Timing
- All outputs are registered or decoded directly from state registers; no combinational input-to-output path.
- With start sampled at edge E and latched limit L:
  - complete sampled at any edge E+1..E+L → IDLE, no timeout.
  - If complete is absent through edge E+L, req_timeout rises after edge E+L and timeout_events increments after the same edge.
  - complete at exactly edge E+L wins over timeout.
- busy rises after edge E and falls after the completing edge.
- timeout_any follows req_timeout with no added latency.
- Clear sampled at edge C → req_timeout low after C. The next start is accepted from edge C+1.
- Channels never interact, except through the event counter sum.

## Structure
- Package `wdt_pkg`:
  - state enum `wdt_state_t` {WDT_IDLE, WDT_ACTIVE, WDT_TIMEOUT}.
  - Function `wdt_norm_limit` (maps 0→1).
- Sub-module `watchdog_channel`, parameter CNT_W:
  - Contains one FSM, the counter, the latched limit, and the busy/timeout outputs.
  - Outputs a one-cycle `timeout_pulse` on entry to TIMEOUT.
- Top level:
  - Generate loop of NUM_CH channels.
  - OR reduction for timeout_any.
  - Popcount of the timeout_pulse vector feeding the saturating adder.

## Test plan
- Reset: assert rst_n=0 mid-ACTIVE on channel 0, then release → all outputs 0; channel 0 stays IDLE with no timeout at the old deadline.
- Normal: L=5, start ch0 at E, complete at E+3 → busy high E+1..E+3 (falls after E+3); req_timeout stays 0; timeout_events=0.
- Boundary: L=5, complete at exactly E+5 → no timeout. Repeat with no complete → req_timeout[0]=1 after E+5, timeout_events=1.
- Sticky/clear: a timed-out ch1 ignores start for 10 cycles; clear plus start in the same cycle → IDLE, busy stays 0; a start on the next cycle is accepted.
- Multi-channel: L=3, start ch0..ch3 on the same edge with no completes → all four time out on the same edge; timeout_events=4; timeout_any=1. Clearing only ch2 leaves timeout_any=1.
- Retrigger/limit change/saturation:
  - Retrigger: start ch0 at E with L=4; set timeout_limit=20 at E+1; restart at E+2 → timeout at E+22.
  - Saturation: with EVT_W=2, force 5 timeouts → timeout_events holds 3.
